// File: rtl/vector_pkg.sv
// Shared vector-word layout and command encoding for the vector sequencer.
package vector_pkg;

  localparam int unsigned X_MSB    = 17;
  localparam int unsigned X_LSB    = 10;
  localparam int unsigned Y_MSB    = 9;
  localparam int unsigned Y_LSB    = 2;
  localparam int unsigned LINE_BIT = 1;
  localparam int unsigned POS_BIT  = 0;
  localparam int unsigned FIELD_W  = X_MSB - X_LSB + 1;
  localparam int unsigned WORD_W   = X_MSB + 1;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'b00,
    CMD_MOVE = 2'b01,
    CMD_DRAW = 2'b10,
    CMD_END  = 2'b11
  } cmd_e;

  // Field order mirrors the bit positions above: x, y, {line,pos}.
  typedef struct packed {
    logic [FIELD_W-1:0] x;
    logic [FIELD_W-1:0] y;
    cmd_e               cmd;
  } vec_word_t;

  function automatic vec_word_t decode_word(input logic [WORD_W-1:0] w);
    vec_word_t d;
    d.x   = w[X_MSB:X_LSB];
    d.y   = w[Y_MSB:Y_LSB];
    d.cmd = cmd_e'({w[LINE_BIT], w[POS_BIT]});
    return d;
  endfunction

endpackage

// File: rtl/vector_clamp.sv
// Combinational clamp of one unsigned coordinate into [FRAME_MIN, FRAME_MAX].
module vector_clamp #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned FRAME_MIN = 0,
  parameter int unsigned FRAME_MAX = 255
) (
  input  logic [WIDTH-1:0] val_i,
  output logic [WIDTH-1:0] val_c
);

  localparam logic [WIDTH:0]   LO_EXT = (WIDTH+1)'(FRAME_MIN);
  localparam logic [WIDTH:0]   HI_EXT = (WIDTH+1)'(FRAME_MAX);
  localparam logic [WIDTH-1:0] LO_N   = WIDTH'(FRAME_MIN);
  localparam logic [WIDTH-1:0] HI_N   = WIDTH'(FRAME_MAX);

  logic [WIDTH:0] ext_c;
  assign ext_c = {1'b0, val_i};

  // "val+1 <= MIN" is "val < MIN" without a constant-false compare when MIN is 0.
  always_comb begin
    val_c = val_i;
    if ((ext_c + (WIDTH+1)'(1)) <= LO_EXT) begin
      val_c = LO_N;
    end else if (ext_c > HI_EXT) begin
      val_c = HI_N;
    end
  end

endmodule

// File: rtl/vector_sequencer.sv
// Walks a vector list in RAM, tracks the pen, and hands clamped line segments
// to a line drawer over a valid/ready handshake.
module vector_sequencer
  import vector_pkg::*;
#(
  parameter int unsigned OUT_WIDTH = 8,
  parameter int unsigned ADR_WIDTH = 16,
  parameter int unsigned DATAWIDTH = 18,
  parameter int unsigned FRAME_MIN = 0,
  parameter int unsigned FRAME_MAX = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 draw_frame,
  output logic                 frame_done,
  output logic [ADR_WIDTH-1:0] adrREAD,
  input  logic [DATAWIDTH-1:0] dataREAD,
  output logic [OUT_WIDTH-1:0] x0,
  output logic [OUT_WIDTH-1:0] y0,
  output logic [OUT_WIDTH-1:0] x1,
  output logic [OUT_WIDTH-1:0] y1,
  output logic                 line_valid,
  input  logic                 line_ready,
  output logic [2:0]           state_debug
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_WAIT_RD   = 3'd2,
    S_DECODE    = 3'd3,
    S_ISSUE     = 3'd4,
    S_FRAME_END = 3'd5,
    S_HOLDOFF   = 3'd6
  } state_e;

  localparam logic [ADR_WIDTH-1:0] ADR_LAST = '1;

  state_e               state_q, state_d;
  logic [ADR_WIDTH-1:0] adr_q, adr_d;
  logic [OUT_WIDTH-1:0] pen_x_q, pen_x_d, pen_y_q, pen_y_d;
  logic [OUT_WIDTH-1:0] x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
  logic                 line_valid_q, line_valid_d;
  logic                 frame_done_q, frame_done_d;
  logic                 last_q, last_d;

  vec_word_t            word_c;
  logic [OUT_WIDTH-1:0] x_raw_c, y_raw_c, x_clamp_c, y_clamp_c;
  logic                 advance_c;

  assign word_c  = decode_word(dataREAD[WORD_W-1:0]);
  assign x_raw_c = OUT_WIDTH'(word_c.x);
  assign y_raw_c = OUT_WIDTH'(word_c.y);

  vector_clamp #(
    .WIDTH     (OUT_WIDTH),
    .FRAME_MIN (FRAME_MIN),
    .FRAME_MAX (FRAME_MAX)
  ) u_clamp_x (
    .val_i (x_raw_c),
    .val_c (x_clamp_c)
  );

  vector_clamp #(
    .WIDTH     (OUT_WIDTH),
    .FRAME_MIN (FRAME_MIN),
    .FRAME_MAX (FRAME_MAX)
  ) u_clamp_y (
    .val_i (y_raw_c),
    .val_c (y_clamp_c)
  );

  // Next-state and datapath updates.
  always_comb begin
    state_d      = state_q;
    adr_d        = adr_q;
    pen_x_d      = pen_x_q;
    pen_y_d      = pen_y_q;
    x0_d         = x0_q;
    y0_d         = y0_q;
    x1_d         = x1_q;
    y1_d         = y1_q;
    line_valid_d = line_valid_q;
    frame_done_d = 1'b0;
    last_d       = last_q;
    advance_c    = 1'b0;

    case (state_q)
      S_IDLE: begin
        adr_d   = '0;
        pen_x_d = '0;
        pen_y_d = '0;
        last_d  = 1'b0;
        if (draw_frame) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH:   state_d = S_WAIT_RD;
      S_WAIT_RD: state_d = S_DECODE;
      S_DECODE: begin
        last_d = (adr_q == ADR_LAST);
        case (word_c.cmd)
          CMD_MOVE: begin
            pen_x_d   = x_clamp_c;
            pen_y_d   = y_clamp_c;
            advance_c = 1'b1;
          end
          CMD_DRAW: begin
            x0_d         = pen_x_q;
            y0_d         = pen_y_q;
            x1_d         = x_clamp_c;
            y1_d         = y_clamp_c;
            line_valid_d = 1'b1;
            state_d      = S_ISSUE;
          end
          CMD_END: begin
            state_d      = S_FRAME_END;
            frame_done_d = 1'b1;
          end
          default: advance_c = 1'b1;
        endcase
      end
      S_ISSUE: begin
        if (line_valid_q && line_ready) begin
          pen_x_d      = x1_q;
          pen_y_d      = y1_q;
          line_valid_d = 1'b0;
          advance_c    = 1'b1;
        end
      end
      S_FRAME_END: state_d = S_HOLDOFF;
      S_HOLDOFF: begin
        if (!draw_frame) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The last RAM word ends the frame instead of wrapping the address.
    if (advance_c) begin
      if (last_d) begin
        state_d      = S_FRAME_END;
        frame_done_d = 1'b1;
      end else begin
        adr_d   = adr_q + ADR_WIDTH'(1);
        state_d = S_FETCH;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      adr_q        <= '0;
      pen_x_q      <= '0;
      pen_y_q      <= '0;
      x0_q         <= '0;
      y0_q         <= '0;
      x1_q         <= '0;
      y1_q         <= '0;
      line_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      adr_q        <= adr_d;
      pen_x_q      <= pen_x_d;
      pen_y_q      <= pen_y_d;
      x0_q         <= x0_d;
      y0_q         <= y0_d;
      x1_q         <= x1_d;
      y1_q         <= y1_d;
      line_valid_q <= line_valid_d;
      frame_done_q <= frame_done_d;
      last_q       <= last_d;
    end
  end

  assign frame_done  = frame_done_q;
  assign adrREAD     = adr_q;
  assign x0          = x0_q;
  assign y0          = y0_q;
  assign x1          = x1_q;
  assign y1          = y1_q;
  assign line_valid  = line_valid_q;
  assign state_debug = state_q;

endmodule

// File: doc/vector_sequencer.md
VECTOR_SEQUENCER -- requirements
Module: vector_sequencer

Interface
REQ-001 SHALL have parameter OUT_WIDTH, default 8, coordinate width.
REQ-002 SHALL have parameter ADR_WIDTH, default 16, vector-RAM address width.
REQ-003 SHALL have parameter DATAWIDTH, default 18, vector word width.
REQ-004 SHALL have parameters FRAME_MIN, default 0, and FRAME_MAX, default 255, as the inclusive coordinate clamp range.
REQ-005 SHALL have one clock and an asynchronous, active-high reset: clk input 1 (sole clock), rst input 1 (asynchronous active-high reset).
REQ-006 SHALL have port draw_frame, input, 1 bit: vector list in RAM complete, level.
REQ-007 SHALL have port frame_done, output, 1 bit: one-cycle pulse when the list has been fully issued.
REQ-008 SHALL have port adrREAD, output, ADR_WIDTH bits: registered RAM read address.
REQ-009 SHALL have port dataREAD, input, DATAWIDTH bits: RAM word, valid one cycle after adrREAD.
REQ-010 SHALL have ports x0 and y0, output, OUT_WIDTH bits each: segment start point.
REQ-011 SHALL have ports x1 and y1, output, OUT_WIDTH bits each: segment end point.
REQ-012 SHALL have port line_valid, output, 1 bit: segment request to the line drawer.
REQ-013 SHALL have port line_ready, input, 1 bit: line drawer accepts the segment.
REQ-014 SHALL have port state_debug, output, 3 bits: current state encoding.

Function
REQ-015 SHALL decode words as x=[17:10], y=[9:2], line=[1], pos=[0]; {line,pos}: 01=MOVE, 10=DRAW, 11=END, 00=NOP.
REQ-016 SHALL implement states IDLE, FETCH, WAIT_RD, DECODE, ISSUE, FRAME_END, HOLDOFF.
REQ-017 IDLE: SHALL hold adrREAD=0 and pen=(0,0), and go to FETCH when draw_frame=1.
REQ-018 FETCH->WAIT_RD->DECODE: SHALL present adrREAD in FETCH and sample dataREAD in DECODE, giving a fixed 2-cycle read latency.
REQ-019 DECODE, MOVE: SHALL set pen=(x,y) clamped, increment adrREAD, and go to FETCH.
REQ-020 DECODE, NOP: SHALL increment adrREAD and go to FETCH with no other effect.
REQ-021 DECODE, DRAW: SHALL load x0/y0=pen and x1/y1=(x,y) clamped, assert line_valid the next cycle, and enter ISSUE.
REQ-022 ISSUE: SHALL hold line_valid and x0..y1 stable until the cycle line_valid&line_ready=1.
REQ-023 On that handshake cycle, SHALL set pen=(x1,y1), drop line_valid the next cycle, increment adrREAD, and go to FETCH.
REQ-024 DECODE, END: SHALL go to FRAME_END.
REQ-025 DECODE at adrREAD=2^ADR_WIDTH-1 with a non-END word: SHALL process the word, then go to FRAME_END (no wrap).
REQ-026 FRAME_END: SHALL assert frame_done for exactly one cycle, then go to HOLDOFF.
REQ-027 HOLDOFF: SHALL wait until draw_frame=0, then go to IDLE; a stale-high draw_frame SHALL never restart the frame.
REQ-028 Clamp rule: SHALL map a coordinate below FRAME_MIN to FRAME_MIN and above FRAME_MAX to FRAME_MAX; arithmetic is unsigned OUT_WIDTH.
REQ-029 SHALL ignore draw_frame in all states except IDLE and HOLDOFF.
REQ-030 SHALL keep line_ready without effect when line_valid=0.

Reset
REQ-031 On rst=1, asynchronously: state=IDLE, adrREAD=0, pen=(0,0), x0=y0=x1=y1=0, line_valid=0, frame_done=0.
REQ-032 Reset mid-ISSUE SHALL drop line_valid immediately; the aborted segment is not reissued.

Structure
REQ-033 SHALL place field bit positions and the {line,pos} command enum in vector_pkg; the state enum is local.
REQ-034 SHALL use one combinational sub-module, vector_clamp, for coordinate clamping, instantiated for x and y.

Verification
REQ-035 Words MOVE(10,20), DRAW(50,60), END with ready tied 1 -> one segment (10,20)->(50,60); frame_done 1 cycle later.
REQ-036 DRAW(5,5) first after reset -> segment (0,0)->(5,5).
REQ-037 DRAW(30,40) with line_ready held 0 for 7 cycles -> line_valid high 7+ cycles, x0..y1 unchanged; single accept.
REQ-038 FRAME_MAX=200, MOVE(250,10), DRAW(100,210) -> segment (200,10)->(100,200).
REQ-039 draw_frame held 1 for 3 cycles after frame_done -> no new FETCH until draw_frame=0 then 1 again; adrREAD restarts at 0.
REQ-040 rst asserted while line_valid=1 -> line_valid=0 the same cycle, state_debug=IDLE, adrREAD=0.
